demux_stream: RTL

Registered 1-to-2 stream demultiplexer with valid/ready handshakes: the inverse of the datapath 2:1 select mux. Each accepted word is tagged with its select bit and routed to `out1` (sel=0) or `out2` (sel=1) through a 2-entry in-order buffer, so upstream sees full throughput and downstream may stall independently. It sits between a shared producer (e.g. memory response path) and two consumers (instruction side / data side). Per-output delivery counters support debug and verification.

---
 rtl/demux_stream.sv | 93 +++++++++
 1 files changed

// File: rtl/demux_stream.sv
// Registered 1:2 stream demux: a 2-entry in-order buffer of {sel, data} whose head is steered to out1/out2.
// Latency 1 cycle, 1 word/cycle; the head blocks later words and in_ready falls only when both slots are full.
module demux_stream #(
  parameter int n  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [n-1:0]  in_data,
  input  logic          in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [n-1:0]  out1_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [n-1:0]  out2_data,
  output logic          out2_valid,
  input  logic          out2_ready,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic          busy
);

  logic [1:0]    count_q, count_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt1_q, cnt1_d;
  logic [CW-1:0] cnt2_q, cnt2_d;

  logic [n-1:0]  mem_data_q [2];
  logic [1:0]    mem_sel_q;

  logic          head_vld;
  logic          head_sel;
  logic [n-1:0]  head_data;
  logic          push;
  logic          pop1;
  logic          pop2;
  logic          pop;

  // Outputs decode registered state only; rst_n gating forces them low during reset.
  always_comb begin
    head_vld   = rst_n && (count_q != 2'd0);
    head_sel   = mem_sel_q[rd_ptr_q];
    head_data  = mem_data_q[rd_ptr_q];

    out1_valid = head_vld && !head_sel;
    out2_valid = head_vld && head_sel;
    out1_data  = out1_valid ? head_data : '0;
    out2_data  = out2_valid ? head_data : '0;
    busy       = head_vld;
    in_ready   = rst_n && (count_q != 2'd2);

    push       = in_valid && in_ready;
    pop1       = out1_valid && out1_ready;
    pop2       = out2_valid && out2_ready;
    pop        = pop1 || pop2;

    count_d    = count_q + 2'(push) - 2'(pop);
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    cnt1_d     = cnt1_q + CW'(pop1);
    cnt2_d     = cnt2_q + CW'(pop2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt1_q   <= '0;
      cnt2_q   <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt1_q   <= cnt1_d;
      cnt2_q   <= cnt2_d;
    end
  end

  // Payload storage is not reset; it is never observed while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= in_data;
      mem_sel_q[wr_ptr_q]  <= in_sel;
    end
  end

  assign cnt1 = cnt1_q;
  assign cnt2 = cnt2_q;

endmodule
